// File: rtl/ball_motion_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion_engine_if
// Purpose  : Frame tick, playfield/paddle inputs and ball/score outputs of the
//            ball motion engine.
// Revision : 1.0 - initial release
// ============================================================================
interface ball_motion_engine_if;
    logic        frame_tick;
    logic [31:0] dimensions;
    logic [31:0] left_paddle;
    logic [31:0] right_paddle;
    logic [31:0] ball_position;
    logic        in_play;
    logic        point_pulse;
    logic [7:0]  score_left;
    logic [7:0]  score_right;

    modport master (
        output frame_tick, dimensions, left_paddle, right_paddle,
        input  ball_position, in_play, point_pulse, score_left, score_right
    );

    modport slave (
        input  frame_tick, dimensions, left_paddle, right_paddle,
        output ball_position, in_play, point_pulse, score_left, score_right
    );
endinterface
`default_nettype wire

// File: rtl/ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion_engine
// Purpose  : Per-frame ball motion with wall/paddle bounces, goals, serve
//            delay and scoring. Optional macro BALL_SPEEDUP_EN adds a step_x
//            register that grows on each paddle hit.
// Revision : 1.0 - initial release
// ============================================================================
module ball_motion_engine #(
    parameter int BALL_STEP_X   = 4,
    parameter int BALL_STEP_Y   = 3,
    parameter int BALL_SIZE     = 8,
    parameter int PADDLE_HEIGHT = 100,
    parameter int PADDLE_WIDTH  = 10,
    parameter int SERVE_DELAY   = 60,
    parameter int MAX_STEP_X    = 12
) (
    input logic                 clk,
    input logic                 rst,
    ball_motion_engine_if.slave bus
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_PLAY  = 2'd1,
        S_SCORE = 2'd2
    } state_t;

    localparam logic [15:0] c_STEP_X   = 16'(BALL_STEP_X);
    localparam logic [15:0] c_STEP_Y   = 16'(BALL_STEP_Y);
    localparam logic [16:0] c_STEP_Y_E = 17'(BALL_STEP_Y);
    localparam logic [15:0] c_SIZE     = 16'(BALL_SIZE);
    localparam logic [16:0] c_SIZE_E   = 17'(BALL_SIZE);
    localparam logic [15:0] c_HALF     = 16'(BALL_SIZE / 2);
    localparam logic [16:0] c_PAD_H_E  = 17'(PADDLE_HEIGHT);
    localparam logic [15:0] c_PAD_W    = 16'(PADDLE_WIDTH);
    localparam logic [15:0] c_SERVE    = 16'(SERVE_DELAY);

    if (MAX_STEP_X < BALL_STEP_X) begin : g_bad_step_cfg
        $error("MAX_STEP_X must not be below BALL_STEP_X");
    end

    state_t      r_state, w_state_nxt;
    logic [15:0] r_x, r_y, r_cnt;
    logic [15:0] w_x_nxt, w_y_nxt, w_cnt_nxt;
    logic        r_dx_right, r_dy_down, w_dx_right_nxt, w_dy_down_nxt;
    logic [7:0]  r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;

    logic [15:0] w_width, w_height, w_cx, w_cy, w_ymax, w_xmax;
    logic [15:0] w_lf, w_rf, w_lp_y, w_rp_y, w_step;
    logic [16:0] w_x_e, w_y_e, w_step_e;
    logic        w_ovl_left, w_ovl_right, w_cross_left, w_cross_right;
    logic        w_goal_left, w_goal_right;

    assign w_width  = bus.dimensions[31:16];
    assign w_height = bus.dimensions[15:0];
    assign w_cx     = (w_width >> 1) - c_HALF;
    assign w_cy     = (w_height >> 1) - c_HALF;
    assign w_ymax   = w_height - c_SIZE;
    assign w_xmax   = w_width - c_SIZE;
    assign w_lf     = bus.left_paddle[31:16] + c_PAD_W;
    assign w_rf     = bus.right_paddle[31:16] - c_SIZE;
    assign w_lp_y   = bus.left_paddle[15:0];
    assign w_rp_y   = bus.right_paddle[15:0];

    // Sums are widened by one bit so no comparison can wrap.
    assign w_x_e    = {1'b0, r_x};
    assign w_y_e    = {1'b0, r_y};
    assign w_step_e = {1'b0, w_step};

    assign w_ovl_left    = (w_y_e + c_SIZE_E > {1'b0, w_lp_y}) &&
                           (w_y_e < {1'b0, w_lp_y} + c_PAD_H_E);
    assign w_ovl_right   = (w_y_e + c_SIZE_E > {1'b0, w_rp_y}) &&
                           (w_y_e < {1'b0, w_rp_y} + c_PAD_H_E);
    assign w_cross_left  = (r_x > w_lf) && (w_x_e <= {1'b0, w_lf} + w_step_e);
    assign w_cross_right = (r_x < w_rf) && (w_x_e + w_step_e >= {1'b0, w_rf});

    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_cnt_nxt      = r_cnt;
        w_dx_right_nxt = r_dx_right;
        w_dy_down_nxt  = r_dy_down;
        w_score_l_nxt  = r_score_l;
        w_score_r_nxt  = r_score_r;
        w_goal_left    = 1'b0;
        w_goal_right   = 1'b0;
        case (r_state)
            S_SERVE: begin
                w_x_nxt = w_cx;
                w_y_nxt = w_cy;
                if (bus.frame_tick) begin
                    if (r_cnt + 16'd1 == c_SERVE) begin
                        w_cnt_nxt   = 16'd0;
                        w_state_nxt = S_PLAY;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (r_dy_down) begin
                        if (w_y_e + c_STEP_Y_E >= {1'b0, w_ymax}) begin
                            w_y_nxt       = w_ymax;
                            w_dy_down_nxt = 1'b0;
                        end else begin
                            w_y_nxt = r_y + c_STEP_Y;
                        end
                    end else if (r_y <= c_STEP_Y) begin
                        w_y_nxt       = 16'd0;
                        w_dy_down_nxt = 1'b1;
                    end else begin
                        w_y_nxt = r_y - c_STEP_Y;
                    end

                    if (!r_dx_right) begin
                        if (w_cross_left && w_ovl_left) begin
                            w_x_nxt        = w_lf;
                            w_dx_right_nxt = 1'b1;
                        end else if (r_x <= w_step) begin
                            w_goal_right = 1'b1;
                        end else begin
                            w_x_nxt = r_x - w_step;
                        end
                    end else begin
                        if (w_cross_right && w_ovl_right) begin
                            w_x_nxt        = w_rf;
                            w_dx_right_nxt = 1'b0;
                        end else if (w_x_e + w_step_e >= {1'b0, w_xmax}) begin
                            w_goal_left = 1'b1;
                        end else begin
                            w_x_nxt = r_x + w_step;
                        end
                    end

                    // Re-serve toward the side that just conceded.
                    if (w_goal_left || w_goal_right) begin
                        w_state_nxt = S_SCORE;
                        w_x_nxt     = w_cx;
                        w_y_nxt     = w_cy;
                        if (w_goal_left) begin
                            w_dx_right_nxt = 1'b1;
                            if (r_score_l != 8'hFF) w_score_l_nxt = r_score_l + 8'd1;
                        end else begin
                            w_dx_right_nxt = 1'b0;
                            if (r_score_r != 8'hFF) w_score_r_nxt = r_score_r + 8'd1;
                        end
                    end
                end
            end
            S_SCORE: begin
                w_state_nxt = S_SERVE;
                w_x_nxt     = w_cx;
                w_y_nxt     = w_cy;
            end
            default: w_state_nxt = S_SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_SERVE;
            r_x        <= w_cx;
            r_y        <= w_cy;
            r_cnt      <= 16'd0;
            r_dx_right <= 1'b1;
            r_dy_down  <= 1'b1;
            r_score_l  <= 8'd0;
            r_score_r  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dx_right <= w_dx_right_nxt;
            r_dy_down  <= w_dy_down_nxt;
            r_score_l  <= w_score_l_nxt;
            r_score_r  <= w_score_r_nxt;
        end
    end

`ifdef BALL_SPEEDUP_EN
    localparam logic [15:0] c_MAX_STEP = 16'(MAX_STEP_X);
    logic [15:0] r_step_x;
    logic        w_hit;

    // A goal never changes dx, so a dx flip in PLAY is exactly a paddle hit.
    assign w_hit = (r_state == S_PLAY) && (w_dx_right_nxt != r_dx_right);

    always_ff @(posedge clk) begin
        if (!rst || w_goal_left || w_goal_right) begin
            r_step_x <= c_STEP_X;
        end else if (w_hit && (r_step_x < c_MAX_STEP)) begin
            r_step_x <= r_step_x + 16'd1;
        end
    end

    assign w_step = r_step_x;
`else
    assign w_step = c_STEP_X;
`endif

    assign bus.ball_position = {r_x, r_y};
    assign bus.in_play       = (r_state == S_PLAY);
    assign bus.point_pulse   = (r_state == S_SCORE);
    assign bus.score_left    = r_score_l;
    assign bus.score_right   = r_score_r;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion_engine
// Purpose  : Self-checking bench for ball_motion_engine against a behavioural
//            game model (playfield 640x480, serve delay 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ball_motion_engine;

    localparam int c_SD       = 2;
    localparam int c_P_SERVE  = 0;
    localparam int c_P_PLAY   = 1;
    localparam int c_P_SCORE  = 2;
`ifdef BALL_SPEEDUP_EN
    localparam int c_AFTER_HIT = 585;
`else
    localparam int c_AFTER_HIT = 586;
`endif

    logic clk;
    logic rst;
    ball_motion_engine_if bus ();

    ball_motion_engine #(.SERVE_DELAY(c_SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Game model state
    int m_x, m_y, m_cnt, m_phase, m_sl, m_sr, m_step, m_hits;
    bit m_dxr, m_dyd;
    int lx = 20;
    int rx = 610;

    task automatic model_edge();
        int w, h, cx, cy, ymax, lf, rf, lpy, rpy, nx, ny;
        bit goal_l, goal_r, ovl_l, ovl_r;
        w    = int'(bus.dimensions[31:16]);
        h    = int'(bus.dimensions[15:0]);
        cx   = w / 2 - 4;
        cy   = h / 2 - 4;
        ymax = h - 8;
        lf   = int'(bus.left_paddle[31:16]) + 10;
        rf   = int'(bus.right_paddle[31:16]) - 8;
        lpy  = int'(bus.left_paddle[15:0]);
        rpy  = int'(bus.right_paddle[15:0]);
        if (!rst) begin
            m_x = cx; m_y = cy; m_dxr = 1; m_dyd = 1; m_cnt = 0;
            m_phase = c_P_SERVE; m_sl = 0; m_sr = 0; m_step = 4;
            return;
        end
        if (m_phase == c_P_SCORE) begin
            m_phase = c_P_SERVE; m_x = cx; m_y = cy;
        end else if (m_phase == c_P_SERVE) begin
            m_x = cx; m_y = cy;
            if (bus.frame_tick) begin
                m_cnt++;
                if (m_cnt == c_SD) begin
                    m_cnt = 0;
                    m_phase = c_P_PLAY;
                end
            end
        end else if (bus.frame_tick) begin
            goal_l = 0; goal_r = 0;
            ovl_l = (m_y + 8 > lpy) && (m_y < lpy + 100);
            ovl_r = (m_y + 8 > rpy) && (m_y < rpy + 100);
            if (m_dyd) begin
                if (m_y + 3 >= ymax) begin ny = ymax; m_dyd = 0; end
                else ny = m_y + 3;
            end else begin
                if (m_y <= 3) begin ny = 0; m_dyd = 1; end
                else ny = m_y - 3;
            end
            nx = m_x;
            if (!m_dxr) begin
                if (m_x > lf && m_x <= lf + m_step && ovl_l) begin
                    nx = lf; m_dxr = 1; m_hits++;
`ifdef BALL_SPEEDUP_EN
                    if (m_step < 12) m_step++;
`endif
                end else if (m_x <= m_step) goal_r = 1;
                else nx = m_x - m_step;
            end else begin
                if (m_x < rf && m_x + m_step >= rf && ovl_r) begin
                    nx = rf; m_dxr = 0; m_hits++;
`ifdef BALL_SPEEDUP_EN
                    if (m_step < 12) m_step++;
`endif
                end else if (m_x + m_step >= w - 8) goal_l = 1;
                else nx = m_x + m_step;
            end
            if (goal_l || goal_r) begin
                m_phase = c_P_SCORE; m_x = cx; m_y = cy; m_step = 4;
                if (goal_l) begin m_dxr = 1; if (m_sl < 255) m_sl++; end
                else        begin m_dxr = 0; if (m_sr < 255) m_sr++; end
            end else begin
                m_x = nx; m_y = ny;
            end
        end
    endtask

    function automatic logic [49:0] model_exp();
        return {16'(m_x), 16'(m_y), m_phase == c_P_PLAY, m_phase == c_P_SCORE,
                8'(m_sl), 8'(m_sr)};
    endfunction

    function automatic logic [49:0] dut_obs();
        return {bus.ball_position, bus.in_play, bus.point_pulse,
                bus.score_left, bus.score_right};
    endfunction

    function automatic logic [15:0] track(input int off);
        int v;
        v = m_y - off;
        if (v < 0) v = 0;
        return 16'(v);
    endfunction

    task automatic drive_edge(input bit t, input bit r, input logic [15:0] lpy,
                              input logic [15:0] rpy);
        bus.frame_tick   = t;
        rst              = r;
        bus.left_paddle  = {16'(lx), lpy};
        bus.right_paddle = {16'(rx), rpy};
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive_edge(1, 0, 16'd200, 16'd200);
        drive_edge(0, 0, 16'd200, 16'd200);
        n_checks++;
        if (dut_obs() !== {16'd316, 16'd236, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h required %h", dut_obs(),
                     {16'd316, 16'd236, 1'b0, 1'b0, 8'd0, 8'd0});
        end
        drive_edge(0, 1, 16'd200, 16'd200);
        n_checks++;
        if (dut_obs() !== model_exp()) begin
            n_fail++;
            $display("FAIL reset_release: got %h required %h", dut_obs(), model_exp());
        end
    endtask

    task automatic test_serve();
        drive_edge(1, 1, 16'd200, 16'd200);
        n_checks++;
        if (bus.in_play !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_first_tick in_play: got %b required 0", bus.in_play);
        end
        drive_edge(1, 1, 16'd200, 16'd200);
        n_checks++;
        if ({bus.in_play, bus.ball_position} !== {1'b1, 16'd316, 16'd236}) begin
            n_fail++;
            $display("FAIL serve_release: got %b/%h required 1/%h", bus.in_play,
                     bus.ball_position, {16'd316, 16'd236});
        end
        drive_edge(1, 1, 16'd200, 16'd200);
        n_checks++;
        if (bus.ball_position !== {16'd320, 16'd239}) begin
            n_fail++;
            $display("FAIL first_move: got %h required %h", bus.ball_position,
                     {16'd320, 16'd239});
        end
    endtask

    task automatic test_paddle_hit();
        bit hit;
        rx = 598;
        drive_edge(0, 0, 16'd200, 16'd200);
        drive_edge(1, 1, 16'd200, 16'd200);
        drive_edge(1, 1, 16'd200, 16'd200);
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            drive_edge(1, 1, 16'd200, track(20));
            n_checks++;
            if (dut_obs() !== model_exp()) begin
                n_fail++;
                $display("FAIL hit_cycle%0d: got %h required %h", i, dut_obs(), model_exp());
            end
            hit = !m_dxr;
        end
        n_checks++;
        if (!hit || bus.ball_position[31:16] !== 16'd590) begin
            n_fail++;
            $display("FAIL paddle_hit_x: got %0d (hit=%0b) required 590",
                     bus.ball_position[31:16], hit);
        end
        drive_edge(1, 1, 16'd200, track(20));
        n_checks++;
        if (bus.ball_position[31:16] !== 16'(c_AFTER_HIT)) begin
            n_fail++;
            $display("FAIL after_hit_x: got %0d required %0d",
                     bus.ball_position[31:16], c_AFTER_HIT);
        end
    endtask

    task automatic test_goal();
        bit seen;
        rx = 598;
        drive_edge(0, 0, 16'd200, 16'd0);
        drive_edge(1, 1, 16'd200, 16'd0);
        drive_edge(1, 1, 16'd200, 16'd0);
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            drive_edge(1, 1, 16'd200, (m_y < 240) ? 16'd370 : 16'd0);
            n_checks++;
            if (dut_obs() !== model_exp()) begin
                n_fail++;
                $display("FAIL goal_cycle%0d: got %h required %h", i, dut_obs(), model_exp());
            end
            seen = bus.point_pulse;
        end
        n_checks++;
        if (dut_obs() !== {16'd316, 16'd236, 1'b0, 1'b1, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL goal_state: got %h required %h", dut_obs(),
                     {16'd316, 16'd236, 1'b0, 1'b1, 8'd1, 8'd0});
        end
        drive_edge(1, 1, 16'd200, 16'd0);
        n_checks++;
        if (bus.point_pulse !== 1'b0 || bus.score_left !== 8'd1) begin
            n_fail++;
            $display("FAIL goal_pulse_width: got pulse=%b score=%0d required 0/1",
                     bus.point_pulse, bus.score_left);
        end
        drive_edge(1, 1, 16'd200, 16'd0);
        drive_edge(1, 1, 16'd200, 16'd0);
        drive_edge(1, 1, 16'd200, 16'd0);
        n_checks++;
        if (bus.ball_position[31:16] !== 16'd320) begin
            n_fail++;
            $display("FAIL reserve_dir: got x=%0d required 320", bus.ball_position[31:16]);
        end
    endtask

    task automatic test_reset_midplay();
        int n;
        n = 5 + int'($urandom_range(0, 20));
        for (int i = 0; i < n; i++) drive_edge(1, 1, 16'd200, track(20));
        drive_edge(1, 0, 16'd200, track(20));
        n_checks++;
        if (dut_obs() !== {16'd316, 16'd236, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_midplay: got %h required %h", dut_obs(),
                     {16'd316, 16'd236, 1'b0, 1'b0, 8'd0, 8'd0});
        end
        drive_edge(0, 1, 16'd200, 16'd200);
    endtask

    task automatic test_random();
        logic [15:0] lpy, rpy;
        bit t, r;
        lx = 20;
        rx = 610;
        for (int i = 0; i < 4000; i++) begin
            t   = ($urandom_range(0, 9) < 6);
            r   = ($urandom_range(0, 699) != 0);
            lpy = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 479))
                                               : track(int'($urandom_range(0, 90)));
            rpy = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 479))
                                               : track(int'($urandom_range(0, 90)));
            drive_edge(t, r, lpy, rpy);
            n_checks++;
            if (dut_obs() !== model_exp()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h required %h", i, dut_obs(), model_exp());
            end
        end
    endtask

`ifdef BALL_SPEEDUP_EN
    task automatic test_speedup();
        int x0, d;
        lx = 20;
        rx = 610;
        drive_edge(0, 0, 16'd200, 16'd200);
        m_hits = 0;
        for (int i = 0; i < 5000 && m_hits < 10; i++) begin
            drive_edge(1, 1, track(40), track(40));
            n_checks++;
            if (dut_obs() !== model_exp()) begin
                n_fail++;
                $display("FAIL speedup_cycle%0d: got %h required %h", i, dut_obs(), model_exp());
            end
        end
        x0 = int'(bus.ball_position[31:16]);
        drive_edge(1, 1, track(40), track(40));
        d = int'(bus.ball_position[31:16]) - x0;
        if (d < 0) d = -d;
        n_checks++;
        if (m_hits < 10 || d != 12) begin
            n_fail++;
            $display("FAIL speedup_step: got %0d after %0d hits required 12", d, m_hits);
        end
    endtask
`endif

    initial begin
        rst              = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.dimensions   = {16'd640, 16'd480};
        bus.left_paddle  = {16'd20, 16'd200};
        bus.right_paddle = {16'd610, 16'd200};
        m_hits           = 0;
        test_reset();
        test_serve();
        test_paddle_hit();
        test_goal();
        test_reset_midplay();
        test_random();
`ifdef BALL_SPEEDUP_EN
        test_speedup();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ball_motion_engine.md
Name: ball_motion_engine

Overview:
- Game-physics block that produces the ball position consumed by the paddle controllers.
- Reads both paddle positions and the playfield dimensions.
- Advances the ball once per frame tick, handling wall bounces, paddle hits, goals, serve delay and scoring.
- Position format is packed {x[31:16], y[15:0]}; dimensions format is {width[31:16], height[15:0]}.

Parameters:
- BALL_STEP_X, 4, horizontal pixels moved per frame tick.
- BALL_STEP_Y, 3, vertical pixels moved per frame tick.
- BALL_SIZE, 8, square ball edge length in pixels.
- PADDLE_HEIGHT, 100, paddle extent in y, starting at paddle y (top edge).
- PADDLE_WIDTH, 10, paddle extent in x, starting at paddle x (left edge).
- SERVE_DELAY, 60, frame ticks the ball waits at centre before moving.
- MAX_STEP_X, 12, ceiling on horizontal step (used only with the optional feature).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- frame_tick  input  1  one-cycle pulse per video frame.
- dimensions  input  32  {width, height} of the playfield.
- left_paddle  input  32  {x, y} of the left paddle top-left corner.
- right_paddle  input  32  {x, y} of the right paddle top-left corner.
- ball_position  output  32  {x, y} of the ball top-left corner.
- in_play  output  1  high while the ball is moving (PLAY state).
- point_pulse  output  1  one-cycle pulse when a goal is scored.
- score_left  output  8  points won by the left player.
- score_right  output  8  points won by the right player.

Behaviour:
- Definitions:
  - CX = width/2 - BALL_SIZE/2; CY = height/2 - BALL_SIZE/2.
  - LF = left_paddle.x + PADDLE_WIDTH; RF = right_paddle.x - BALL_SIZE.
  - YMAX = height - BALL_SIZE.
  - All arithmetic is 16-bit unsigned. Comparisons are evaluated so that no wrap occurs (x < STEP is tested before any subtraction).
- Reset (rst==0 at a clk edge):
  - ball_position = {CX, CY}; score_left = score_right = 0; point_pulse = 0; in_play = 0.
  - dx = right, dy = down, serve counter = 0, state = SERVE.
  - Reset asserted mid-operation abandons any point in progress; scores clear.
- States: SERVE, PLAY, SCORE.
- SERVE:
  - Ball is held at {CX, CY}.
  - Each frame_tick increments the serve counter.
  - On the tick that makes counter == SERVE_DELAY: counter is cleared, state goes to PLAY, and in_play rises on the following cycle.
  - The ball does not move on that tick.
- PLAY: on each frame_tick, x and y update in the same cycle, using pre-update values for all checks.
  - Vertical, moving up:
    - If y <= BALL_STEP_Y: y = 0 and dy = down.
    - Else y -= BALL_STEP_Y.
  - Vertical, moving down:
    - If y + BALL_STEP_Y >= YMAX: y = YMAX and dy = up.
    - Else y += BALL_STEP_Y.
  - Horizontal, moving left:
    - Crossing when x > LF and x <= LF + step. If crossing and overlap with the left paddle: x = LF, dx = right.
    - Else if x <= step: goal for right, go to SCORE.
    - Else x -= step.
  - Horizontal, moving right:
    - Crossing when x < RF and x + step >= RF. If crossing and overlap with the right paddle: x = RF, dx = left.
    - Else if x + step >= width - BALL_SIZE: goal for left, go to SCORE.
    - Else x += step.
  - Overlap with a paddle is true when y + BALL_SIZE > paddle.y and y < paddle.y + PADDLE_HEIGHT.
  - frame_tick has no effect outside PLAY, except counting in SERVE.
- SCORE: lasts exactly one clk cycle, independent of frame_tick.
  - point_pulse = 1.
  - The scorer's counter increments and saturates at 255.
  - ball_position returns to {CX, CY}; dx points toward the side that conceded; dy is unchanged.
  - in_play = 0; next state is SERVE.
- Latency: outputs update on the clk edge that samples frame_tick, so they are visible one cycle after the tick.
- Dimensions and paddle inputs are sampled combinationally every cycle and are not latched.
- Changing dimensions during PLAY is unsupported; the ball continues from its current position.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- When defined:
  - A step_x register (reset and serve value BALL_STEP_X) increments by 1 on every paddle hit, saturating at MAX_STEP_X.
  - step_x returns to BALL_STEP_X when the SCORE state is entered.
- When undefined: step is constantly BALL_STEP_X, no register exists, and MAX_STEP_X is unused.

Test Plan (bench values: dimensions = {640, 480}, SERVE_DELAY = 2, default steps):
- Reset, then release -> ball_position = {316, 236}, scores 0, in_play 0. After 2 frame_ticks in_play = 1. The next tick gives {320, 239}.
- Ball moving up at y = 2 with a tick -> y = 0, dy = down. The next tick gives y = 3.
- right_paddle = {600, 200}, ball moving right at {590, 250}, tick -> x = 592, dx = left. The next tick gives x = 588.
- right_paddle = {600, 0}, ball moving right with y = 400 and x = 628, tick -> one-cycle point_pulse, score_left = 1, ball_position = {316, 236}, in_play = 0. After 2 ticks the ball moves right.
- Assert rst during PLAY at an arbitrary cycle -> the next edge shows reset values, including score 0. A frame_tick coincident with the reset is ignored.
- With BALL_SPEEDUP_EN defined, 10 consecutive paddle hits -> step grows 5, 6, … and saturates at 12. After a goal, the first moving tick advances x by 4.
